// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 datapath control.
// Contents: controller FSM state type, Rcon constants, round-count limits and
// the GF(2^8) xtime helper used by the round-constant generator.
package aes_pkg;

   // Controller states; explicit 2-bit encoding.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StInit  = 2'd1,
      StRound = 2'd2,
      StDone  = 2'd3
   } stateT;

   localparam logic [7:0]  RCON_INIT = 8'h01;
   localparam logic [7:0]  RCON_POLY = 8'h1B;
   localparam int unsigned AES128_NR = 10;
   localparam int unsigned ROUND_W   = 4;

   // Multiply by x in GF(2^8) modulo the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// 8-bit AES round-constant register.
// Ports:
//   iClk, iRsn  clock and asynchronous active-low reset
//   iInit       reload the register with RCON_INIT (wins over iAdvance)
//   iAdvance    step the register by xtime
//   oRcon       current round constant
module aes_rcon_gen
   import aes_pkg::*;
(
   input  logic       iClk,
   input  logic       iRsn,
   input  logic       iInit,
   input  logic       iAdvance,
   output logic [7:0] oRcon
);

   logic [7:0] rconQ;
   logic [7:0] rconD;

   always_comb begin
      rconD = rconQ;
      if (iInit) begin
         rconD = RCON_INIT;
      end else if (iAdvance) begin
         rconD = xtime(rconQ);
      end
   end

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         rconQ <= RCON_INIT;
      end else begin
         rconQ <= rconD;
      end
   end

   assign oRcon = rconQ;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for an iterative AES-128 round datapath. Pure control: walks the
// datapath through one initial key-add cycle and NUM_ROUNDS rounds of
// CYCLES_PER_ROUND clocks each, then holds the result valid until accepted.
// Ports:
//   iClk, iRsn  clock and asynchronous active-low reset
//   iStart      start request, taken only while oReady=1 and iClear=0
//   iClear      synchronous abort to idle, overrides everything else
//   iOutReady   consumer handshake while oValid=1
//   oReady      idle, can accept iStart
//   oBusy       initial load or round in progress
//   oLoadSel    datapath selects plaintext XOR key (round 0)
//   oStateEn    state register load enable
//   oKeyEn      round-key register load/advance enable
//   oFinal      last round, datapath bypasses MixColumns
//   oRound      current round index
//   oRcon       round constant for oRound (zero outside rounds)
//   oValid      result valid in the state register
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS       = AES128_NR,
   parameter int unsigned CYCLES_PER_ROUND = 1
) (
   input  logic               iClk,
   input  logic               iRsn,
   input  logic               iStart,
   input  logic               iClear,
   input  logic               iOutReady,
   output logic               oReady,
   output logic               oBusy,
   output logic               oLoadSel,
   output logic               oStateEn,
   output logic               oKeyEn,
   output logic               oFinal,
   output logic [ROUND_W-1:0] oRound,
   output logic [7:0]         oRcon,
   output logic               oValid
);

   localparam logic [2:0]         SUB_LAST   = 3'(CYCLES_PER_ROUND - 1);
   localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NUM_ROUNDS);

   stateT              stateQ, stateD;
   logic [ROUND_W-1:0] roundQ, roundD;
   logic [2:0]         subCntQ, subCntD;
   logic               rconInit, rconAdv;
   logic [7:0]         rconVal;
   logic               lastSub, lastRound;

   assign lastSub   = (subCntQ == SUB_LAST);
   assign lastRound = (roundQ == ROUND_LAST);

   aes_rcon_gen uRconGen (
      .iClk     (iClk),
      .iRsn     (iRsn),
      .iInit    (rconInit),
      .iAdvance (rconAdv),
      .oRcon    (rconVal)
   );

   always_comb begin
      stateD   = stateQ;
      roundD   = roundQ;
      subCntD  = subCntQ;
      rconInit = 1'b0;
      rconAdv  = 1'b0;
      oReady   = 1'b0;
      oBusy    = 1'b0;
      oLoadSel = 1'b0;
      oStateEn = 1'b0;
      oKeyEn   = 1'b0;
      oFinal   = 1'b0;
      oRcon    = 8'h00;
      oValid   = 1'b0;

      unique case (stateQ)
         StIdle: begin
            oReady = 1'b1;
            if (iStart) begin
               stateD = StInit;
            end
         end
         StInit: begin
            oBusy    = 1'b1;
            oLoadSel = 1'b1;
            oStateEn = 1'b1;
            oKeyEn   = 1'b1;
            rconInit = 1'b1;
            stateD   = StRound;
            roundD   = ROUND_W'(1);
            subCntD  = 3'd0;
         end
         StRound: begin
            oBusy  = 1'b1;
            oFinal = lastRound;
            oRcon  = rconVal;
            if (lastSub) begin
               oStateEn = 1'b1;
               oKeyEn   = 1'b1;
               subCntD  = 3'd0;
               if (lastRound) begin
                  // Round index stays at NUM_ROUNDS while the result waits.
                  stateD = StDone;
               end else begin
                  roundD  = roundQ + ROUND_W'(1);
                  rconAdv = 1'b1;
               end
            end else begin
               subCntD = subCntQ + 3'd1;
            end
         end
         StDone: begin
            oValid = 1'b1;
            if (iOutReady) begin
               stateD = StIdle;
               roundD = '0;
            end
         end
         default: begin
            stateD = StIdle;
         end
      endcase

      // Abort: drop to idle and suppress any register update this cycle.
      if (iClear) begin
         stateD   = StIdle;
         roundD   = '0;
         subCntD  = 3'd0;
         oStateEn = 1'b0;
         oKeyEn   = 1'b0;
         rconAdv  = 1'b0;
         rconInit = 1'b1;
      end
   end

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         stateQ  <= StIdle;
         roundQ  <= '0;
         subCntQ <= 3'd0;
      end else begin
         stateQ  <= stateD;
         roundQ  <= roundD;
         subCntQ <= subCntD;
      end
   end

   assign oRound = roundQ;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: three instances (defaults, 3 cycles/round, 1 round)
// driven by shared stimulus and checked every cycle against an elapsed-time
// model, plus literal expectations for the documented timelines.
module tb_aes_round_ctrl;

   localparam int NI = 3;
   localparam int unsigned NR_TAB [NI] = '{10, 10, 1};
   localparam int unsigned CPR_TAB[NI] = '{1, 3, 1};

   logic iClk = 1'b0;
   logic iRsn, iStart, iClear, iOutReady;

   logic       ready[NI], busy[NI], loadSel[NI], stateEn[NI], keyEn[NI], fin[NI], valid[NI];
   logic [3:0] rnd[NI];
   logic [7:0] rcon[NI];
   logic [18:0] obs[NI];

   int vectors = 0;
   int miscompares = 0;
   bit cmpOn = 1'b0;

   logic [7:0] rconTab[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

   always #5 iClk = ~iClk;

   for (genvar g = 0; g < NI; g++) begin : gDut
      aes_round_ctrl #(
         .NUM_ROUNDS       (NR_TAB[g]),
         .CYCLES_PER_ROUND (CPR_TAB[g])
      ) uDut (
         .iClk      (iClk),
         .iRsn      (iRsn),
         .iStart    (iStart),
         .iClear    (iClear),
         .iOutReady (iOutReady),
         .oReady    (ready[g]),
         .oBusy     (busy[g]),
         .oLoadSel  (loadSel[g]),
         .oStateEn  (stateEn[g]),
         .oKeyEn    (keyEn[g]),
         .oFinal    (fin[g]),
         .oRound    (rnd[g]),
         .oRcon     (rcon[g]),
         .oValid    (valid[g])
      );
      assign obs[g] = {ready[g], busy[g], loadSel[g], stateEn[g], keyEn[g], fin[g],
                       rnd[g], rcon[g], valid[g]};
   end

   // Model: phase 0 idle, 1 running (el = cycles since start, 1 = key-add),
   // 2 result waiting.
   int ph[NI];
   int el[NI];

   always @(posedge iClk or negedge iRsn) begin
      for (int g = 0; g < NI; g++) begin
         if (!iRsn || iClear) begin
            ph[g] <= 0;
            el[g] <= 0;
         end else if (ph[g] == 0) begin
            if (iStart) begin
               ph[g] <= 1;
               el[g] <= 1;
            end
         end else if (ph[g] == 1) begin
            if (el[g] == 1 + int'(NR_TAB[g] * CPR_TAB[g])) ph[g] <= 2;
            else el[g] <= el[g] + 1;
         end else if (iOutReady) begin
            ph[g] <= 0;
         end
      end
   end

   function automatic logic [18:0] expOut(int g);
      logic rdy, bsy, ld, se, ke, fn, vl;
      logic [3:0] r;
      logic [7:0] rc;
      int k, ri;
      {rdy, bsy, ld, se, ke, fn, vl} = '0;
      r  = 4'd0;
      rc = 8'h00;
      if (ph[g] == 0) begin
         rdy = 1'b1;
      end else if (ph[g] == 1) begin
         bsy = 1'b1;
         if (el[g] == 1) begin
            ld = 1'b1; se = 1'b1; ke = 1'b1;
         end else begin
            k  = el[g] - 2;
            ri = k / int'(CPR_TAB[g]) + 1;
            r  = 4'(ri);
            se = (k % int'(CPR_TAB[g])) == int'(CPR_TAB[g]) - 1;
            ke = se;
            fn = (ri == int'(NR_TAB[g]));
            rc = rconTab[ri-1];
         end
      end else begin
         vl = 1'b1;
         r  = 4'(NR_TAB[g]);
      end
      if (iClear) begin
         se = 1'b0; ke = 1'b0;
      end
      return {rdy, bsy, ld, se, ke, fn, r, rc, vl};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge iClk) begin
      if (cmpOn) begin
         for (int g = 0; g < NI; g++) begin
            chk($sformatf("dut%0d_outputs", g), 32'(obs[g]), 32'(expOut(g)));
         end
      end
   end

   task automatic nextCycle();
      @(posedge iClk);
      #1;
   endtask

   task automatic chkResetVals(input string tag);
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("%s_ready%0d", tag, g), 32'(ready[g]), 32'd1);
         chk($sformatf("%s_valid%0d", tag, g), 32'(valid[g]), 32'd0);
         chk($sformatf("%s_busy%0d", tag, g), 32'(busy[g]), 32'd0);
         chk($sformatf("%s_round%0d", tag, g), 32'(rnd[g]), 32'd0);
         chk($sformatf("%s_rcon%0d", tag, g), 32'(rcon[g]), 32'h00);
      end
   endtask

   initial begin
      bit found;
      iRsn = 1'b0; iStart = 1'b0; iClear = 1'b0; iOutReady = 1'b0;
      repeat (2) @(posedge iClk);
      @(negedge iClk);
      iRsn = 1'b1;
      cmpOn = 1'b1;
      #1 chkResetVals("reset");

      // Single start pulse; cycle c counts from the INIT cycle (c=1).
      nextCycle(); iStart = 1'b1;
      nextCycle(); iStart = 1'b0;
      for (int c = 1; c <= 36; c++) begin
         @(negedge iClk);
         if (c == 1) chk("d0_loadsel_c1", 32'(loadSel[0]), 32'd1);
         if (c >= 2 && c <= 11) begin
            chk($sformatf("d0_round_c%0d", c), 32'(rnd[0]), 32'(c - 1));
            chk($sformatf("d0_rcon_c%0d", c), 32'(rcon[0]), 32'(rconTab[c-2]));
         end
         chk($sformatf("d0_final_c%0d", c), 32'(fin[0]), 32'(c == 11));
         chk($sformatf("d0_valid_c%0d", c), 32'(valid[0]), 32'(c >= 12));
         chk($sformatf("d1_stateen_c%0d", c), 32'(stateEn[1]),
             32'(c == 1 || (c >= 4 && c <= 31 && (c - 4) % 3 == 0)));
         if (c >= 2 && c <= 31)
            chk($sformatf("d1_round_c%0d", c), 32'(rnd[1]), 32'((c - 2) / 3 + 1));
         chk($sformatf("d1_valid_c%0d", c), 32'(valid[1]), 32'(c >= 32));
         chk($sformatf("d2_final_c%0d", c), 32'(fin[2]), 32'(c == 2));
         if (c == 2) chk("d2_rcon_c2", 32'(rcon[2]), 32'h01);
         chk($sformatf("d2_valid_c%0d", c), 32'(valid[2]), 32'(c >= 3));
         nextCycle();
         // Start pulses while running or holding a result must be ignored.
         iStart = (c == 4 || c == 19);
      end
      iStart = 1'b0;
      iOutReady = 1'b1;
      nextCycle();
      iOutReady = 1'b0;
      @(negedge iClk);
      chkResetVals("handshake");

      // Abort at round 5.
      nextCycle(); iStart = 1'b1;
      nextCycle(); iStart = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge iClk);
         if (rnd[0] == 4'd5) found = 1'b1;
      end
      chk("wait_round5", 32'(found), 32'd1);
      #1 iClear = 1'b1;
      #1 chk("clear_no_stateen", 32'(stateEn[0]), 32'd0);
      chk("clear_no_keyen", 32'(keyEn[0]), 32'd0);
      nextCycle(); iClear = 1'b0;
      @(negedge iClk);
      chkResetVals("clear");
      nextCycle(); iStart = 1'b1;
      nextCycle(); iStart = 1'b0;
      nextCycle();
      @(negedge iClk);
      chk("restart_round", 32'(rnd[0]), 32'd1);
      chk("restart_rcon", 32'(rcon[0]), 32'h01);

      // Start together with clear while idle is ignored.
      nextCycle(); iClear = 1'b1;
      nextCycle(); iClear = 1'b0; iStart = 1'b1;
      #1 iStart = 1'b0;
      iClear = 1'b1; iStart = 1'b1;
      nextCycle(); iClear = 1'b0; iStart = 1'b0;
      @(negedge iClk);
      chkResetVals("start_and_clear");

      // Held start and consumer always ready: back-to-back operations.
      nextCycle(); iStart = 1'b1; iOutReady = 1'b1;
      repeat (60) nextCycle();
      iStart = 1'b0; iOutReady = 1'b0;

      // Random traffic with one asynchronous reset in the middle.
      for (int i = 0; i < 3000; i++) begin
         nextCycle();
         iStart    = ($urandom_range(3) == 0);
         iClear    = ($urandom_range(39) == 0);
         iOutReady = $urandom_range(1) == 1;
         if (i == 1500) begin
            #2 iRsn = 1'b0;
            #1 chkResetVals("async_reset");
            @(posedge iClk);
            #3 iRsn = 1'b1;
         end
      end
      nextCycle();
      iStart = 1'b0; iClear = 1'b0; iOutReady = 1'b0;
      @(negedge iClk);
      #1 cmpOn = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
